// File: rtl/hamming_pkg.sv
// Shared definitions for the (16,11) SECDED Hamming code: bit positions, flags, decoder states.
`default_nettype none

package hamming_pkg;

   localparam int unsigned P0 = 0;
   localparam int unsigned P1 = 1;
   localparam int unsigned P2 = 2;
   localparam int unsigned P4 = 4;
   localparam int unsigned P8 = 8;

   // Positions holding check bits; all remaining positions carry d1..d11 in ascending order.
   localparam logic [15:0] PARITY_MASK =
      16'((1 << P0) | (1 << P1) | (1 << P2) | (1 << P4) | (1 << P8));

   typedef enum logic [1:0] {
      CLEAN  = 2'b00,
      SINGLE = 2'b01,
      DOUBLE = 2'b10
   } flag_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD_LO  = 3'd1,
      RD_HI  = 3'd2,
      CAP_HI = 3'd3,
      DECODE = 3'd4,
      WR_LO  = 3'd5,
      WR_HI  = 3'd6,
      DONE   = 3'd7
   } dec_state_t;

endpackage

`default_nettype wire

// File: rtl/secded16_correct.sv
// Combinational SECDED corrector: one 16-bit Hamming word in, 11 data bits and a status flag out.
`default_nettype none

module secded16_correct
   import hamming_pkg::*;
(
   input  logic  [15:0] i_word,
   output logic  [10:0] o_data,
   output flag_t        o_flag
);

   logic [3:0]  w_syn;
   logic        w_par;
   logic [15:0] w_fix;
   logic [3:0]  w_n;

   always_comb begin
      w_syn = '0;
      for (int k = 1; k < 16; k++) begin
         if (i_word[4'(k)]) w_syn = w_syn ^ 4'(k);
      end
      w_par = ^i_word;

      // Odd overall parity means exactly one flip; syndrome 0 then points at p0 itself.
      w_fix = i_word;
      if (w_par) w_fix[w_syn] = ~i_word[w_syn];

      if (w_par)                o_flag = SINGLE;
      else if (w_syn != 4'd0)   o_flag = DOUBLE;
      else                      o_flag = CLEAN;

      o_data = '0;
      w_n    = '0;
      for (int k = 0; k < 16; k++) begin
         if (!PARITY_MASK[4'(k)]) begin
            o_data[w_n] = w_fix[4'(k)];
            w_n         = w_n + 4'd1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/secded_decode_engine.sv
// Memory-side SECDED decode engine: reads encoded words, corrects/flags them, writes results back.
`default_nettype none

module secded_decode_engine
   import hamming_pkg::*;
#(
   parameter int NUM_WORDS = 15,
   parameter int SRC_BASE  = 30,
   parameter int DST_BASE  = 0,
   parameter int AW        = 8
)(
   input  logic          CLK,
   input  logic          RESET_N,
   input  logic          start,
   output logic          halt,
   output logic [AW-1:0] mem_addr,
   output logic          mem_rd_en,
   input  logic [7:0]    mem_rdata,
   output logic          mem_wr_en,
   output logic [7:0]    mem_wdata,
   output logic [3:0]    err1_cnt,
   output logic [3:0]    err2_cnt
);

   localparam int            IW   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);

   dec_state_t    r_state, w_next;
   logic [IW-1:0] r_idx;
   logic [7:0]    r_lo, r_hi;
   logic [10:0]   r_data;
   flag_t         r_flag;
   logic [3:0]    r_err1, r_err2;
   logic          r_halt;

   logic [10:0]   w_data;
   flag_t         w_flag;
   logic [AW-1:0] w_src, w_dst;

   assign w_src = AW'(SRC_BASE + 2 * int'(r_idx));
   assign w_dst = AW'(DST_BASE + 2 * int'(r_idx));

   secded16_correct u_corr (
      .i_word ({r_hi, r_lo}),
      .o_data (w_data),
      .o_flag (w_flag)
   );

   always_comb begin
      w_next    = r_state;
      mem_addr  = '0;
      mem_rd_en = 1'b0;
      mem_wr_en = 1'b0;
      mem_wdata = '0;
      case (r_state)
         IDLE, DONE: if (start) w_next = RD_LO;
         RD_LO: begin
            mem_addr  = w_src;
            mem_rd_en = 1'b1;
            w_next    = RD_HI;
         end
         RD_HI: begin
            mem_addr  = w_src + AW'(1);
            mem_rd_en = 1'b1;
            w_next    = CAP_HI;
         end
         CAP_HI: w_next = DECODE;
         DECODE: w_next = WR_LO;
         WR_LO: begin
            mem_addr  = w_dst;
            mem_wr_en = 1'b1;
            mem_wdata = r_data[7:0];
            w_next    = WR_HI;
         end
         WR_HI: begin
            mem_addr  = w_dst + AW'(1);
            mem_wr_en = 1'b1;
            mem_wdata = {r_flag, 3'b000, r_data[10:8]};
            w_next    = (r_idx == LAST) ? DONE : RD_LO;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_lo    <= '0;
         r_hi    <= '0;
         r_data  <= '0;
         r_flag  <= CLEAN;
         r_err1  <= '0;
         r_err2  <= '0;
         r_halt  <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_idx  <= '0;
                  r_err1 <= '0;
                  r_err2 <= '0;
                  r_halt <= 1'b0;
               end
            end
            RD_HI:  r_lo <= mem_rdata;
            CAP_HI: r_hi <= mem_rdata;
            DECODE: begin
               r_data <= w_data;
               r_flag <= w_flag;
               if (w_flag == SINGLE && r_err1 != 4'hF) r_err1 <= r_err1 + 4'd1;
               if (w_flag == DOUBLE && r_err2 != 4'hF) r_err2 <= r_err2 + 4'd1;
            end
            WR_HI: begin
               if (r_idx == LAST) r_halt <= 1'b1;
               else               r_idx  <= r_idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign halt     = r_halt;
   assign err1_cnt = r_err1;
   assign err2_cnt = r_err2;

endmodule

`default_nettype wire

// File: tb/tb_secded_decode_engine.sv
// Scoreboard bench for secded_decode_engine: expected writes are queued, a monitor checks each one.
`default_nettype none

module tb_secded_decode_engine;

   localparam int NW  = 15;
   localparam int SRC = 30;
   localparam int DST = 0;

   logic       CLK = 1'b0;
   logic       RESET_N = 1'b0;
   logic       start = 1'b0;
   logic       halt;
   logic [7:0] mem_addr;
   logic       mem_rd_en;
   logic [7:0] mem_rdata = 8'h00;
   logic       mem_wr_en;
   logic [7:0] mem_wdata;
   logic [3:0] err1_cnt, err2_cnt;

   always #5 CLK = ~CLK;

   secded_decode_engine #(.NUM_WORDS(NW), .SRC_BASE(SRC), .DST_BASE(DST), .AW(8)) dut (
      .CLK       (CLK),
      .RESET_N   (RESET_N),
      .start     (start),
      .halt      (halt),
      .mem_addr  (mem_addr),
      .mem_rd_en (mem_rd_en),
      .mem_rdata (mem_rdata),
      .mem_wr_en (mem_wr_en),
      .mem_wdata (mem_wdata),
      .err1_cnt  (err1_cnt),
      .err2_cnt  (err2_cnt)
   );

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
   } wr_t;

   wr_t         sb[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [7:0]  src_img [256];
   logic [10:0] msgs [15] = '{11'h001, 11'h7FF, 11'h2AA, 11'h555, 11'h123,
                              11'h456, 11'h789, 11'h0F0, 11'h70F, 11'h3C3,
                              11'h600, 11'h00A, 11'h1B4, 11'h4E2, 11'h35D};

   // Source memory model with one-cycle read latency; writes are only observed.
   always @(posedge CLK) begin
      if (mem_rd_en) mem_rdata <= src_img[mem_addr];
   end

   always @(negedge CLK) begin
      if (mem_rd_en && mem_wr_en) begin
         n_tests++; n_fail++;
         $display("FAIL rd_wr_overlap: rd_en=1 wr_en=1 at addr %0d, required never both", mem_addr);
      end
      if (mem_wr_en) begin
         n_tests++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: addr=%0d data=%h, required no write", mem_addr, mem_wdata);
         end else begin
            wr_t e;
            e = sb.pop_front();
            if (mem_addr !== e.addr || mem_wdata !== e.data) begin
               n_fail++;
               $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                        mem_addr, mem_wdata, e.addr, e.data);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] enc(input logic [10:0] m);
      logic [15:0] w;
      w = '0;
      {w[15], w[14], w[13], w[12], w[11], w[10], w[9], w[7], w[6], w[5], w[3]} = m;
      w[1] = w[3] ^ w[5] ^ w[7] ^ w[9] ^ w[11] ^ w[13] ^ w[15];
      w[2] = w[3] ^ w[6] ^ w[7] ^ w[10] ^ w[11] ^ w[14] ^ w[15];
      w[4] = w[5] ^ w[6] ^ w[7] ^ w[12] ^ w[13] ^ w[14] ^ w[15];
      w[8] = ^w[15:9];
      w[0] = ^w[15:1];
      return w;
   endfunction

   function automatic logic [10:0] ext(input logic [15:0] w);
      return {w[15], w[14], w[13], w[12], w[11], w[10], w[9], w[7], w[6], w[5], w[3]};
   endfunction

   task automatic put_word(input int j, input logic [15:0] w, input logic [7:0] lo, input logic [7:0] hi);
      wr_t e;
      src_img[SRC + 2*j]     = w[7:0];
      src_img[SRC + 2*j + 1] = w[15:8];
      e.addr = 8'(DST + 2*j);     e.data = lo; sb.push_back(e);
      e.addr = 8'(DST + 2*j + 1); e.data = hi; sb.push_back(e);
   endtask

   // Run B image: word j carries no error, one flipped bit or two flipped bits by j mod 3.
   task automatic load_mix();
      logic [15:0] w;
      logic [10:0] m;
      for (int j = 0; j < NW; j++) begin
         w = enc(msgs[j]);
         m = msgs[j];
         case (j % 3)
            1: begin
               w[(j*5) % 16] = ~w[(j*5) % 16];
               put_word(j, w, m[7:0], {2'b01, 3'b000, m[10:8]});
            end
            2: begin
               w[j % 16]       = ~w[j % 16];
               w[(j + 7) % 16] = ~w[(j + 7) % 16];
               m = ext(w);
               put_word(j, w, m[7:0], {2'b10, 3'b000, m[10:8]});
            end
            default: put_word(j, w, m[7:0], {2'b00, 3'b000, m[10:8]});
         endcase
      end
   endtask

   task automatic run_timed(input int pulse_a, input int pulse_b, output int cyc);
      @(negedge CLK); start = 1'b1;
      @(posedge CLK); cyc = 1; #1; start = 1'b0;
      while (!halt && cyc < 400) begin
         start = (cyc == pulse_a || cyc == pulse_b);
         @(posedge CLK); cyc++; #1;
      end
      start = 1'b0;
   endtask

   initial begin
      int cyc;
      logic [10:0] m;
      for (int a = 0; a < 256; a++) src_img[a] = 8'h00;

      repeat (3) @(posedge CLK);
      #1;
      chk("rst_halt",  32'(halt), 0);
      chk("rst_rd_en", 32'(mem_rd_en), 0);
      chk("rst_wr_en", 32'(mem_wr_en), 0);
      chk("rst_addr",  32'(mem_addr), 0);
      chk("rst_wdata", 32'(mem_wdata), 0);
      chk("rst_err1",  32'(err1_cnt), 0);
      chk("rst_err2",  32'(err2_cnt), 0);
      RESET_N = 1'b1;
      repeat (2) @(posedge CLK);

      // Run A: hand-computed directed words, then clean encoded words.
      put_word(0, 16'h000F, 8'h01, 8'h00);
      put_word(1, 16'h002F, 8'h01, 8'h40);
      put_word(2, 16'h000E, 8'h01, 8'h40);
      put_word(3, 16'h0000, 8'h00, 8'h00);
      put_word(4, 16'h022F, 8'h13, 8'h80);
      for (int j = 5; j < NW; j++) begin
         m = msgs[j];
         put_word(j, enc(m), m[7:0], {5'b00000, m[10:8]});
      end
      run_timed(-1, -1, cyc);
      chk("A_latency", 32'(cyc), 91);
      chk("A_err1", 32'(err1_cnt), 2);
      chk("A_err2", 32'(err2_cnt), 1);
      chk("A_drained", 32'(sb.size()), 0);
      repeat (4) @(posedge CLK);
      #1;
      chk("A_halt_hold", 32'(halt), 1);

      // Run B from DONE: mixed errors, counters must restart.
      load_mix();
      run_timed(-1, -1, cyc);
      chk("B_latency", 32'(cyc), 91);
      chk("B_err1", 32'(err1_cnt), 5);
      chk("B_err2", 32'(err2_cnt), 5);
      chk("B_drained", 32'(sb.size()), 0);

      // Run C: reset lands at the start of word 7.
      load_mix();
      @(negedge CLK); start = 1'b1;
      @(posedge CLK); cyc = 1; #1; start = 1'b0;
      while (cyc < 43) begin
         @(posedge CLK); cyc++; #1;
      end
      chk("C_pending", 32'(sb.size()), 16);
      chk("C_mid_err1", 32'(err1_cnt), 2);
      chk("C_mid_err2", 32'(err2_cnt), 2);
      RESET_N = 1'b0;
      sb.delete();
      @(posedge CLK); #1;
      chk("C_halt",  32'(halt), 0);
      chk("C_rd_en", 32'(mem_rd_en), 0);
      chk("C_wr_en", 32'(mem_wr_en), 0);
      chk("C_addr",  32'(mem_addr), 0);
      chk("C_err1",  32'(err1_cnt), 0);
      chk("C_err2",  32'(err2_cnt), 0);
      repeat (2) @(posedge CLK);
      #1; RESET_N = 1'b1;
      repeat (20) @(posedge CLK);
      #1;
      chk("C_idle_halt", 32'(halt), 0);

      // Run D: clean rerun with stray start pulses mid-run and in the final WR_HI.
      load_mix();
      run_timed(30, 90, cyc);
      chk("D_latency", 32'(cyc), 91);
      chk("D_err1", 32'(err1_cnt), 5);
      chk("D_err2", 32'(err2_cnt), 5);
      chk("D_drained", 32'(sb.size()), 0);
      repeat (10) @(posedge CLK);
      #1;
      chk("D_halt_hold", 32'(halt), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
